// File: rtl/inv_key_sched_ctrl.sv
// Iterative AES-128 inverse round-key controller: expands the round-10 key down to round 0
// through one shared InvKeyScheduler, stores all 11 keys and serves indexed reads.
module inv_key_sched_ctrl #(
  parameter int unsigned KEY_W = 128,
  parameter int unsigned NR    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_load,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             keys_ready,
  input  logic             rd_req,
  input  logic [3:0]       rd_round,
  output logic             rd_ack,
  output logic [KEY_W-1:0] rd_key,
  output logic             rd_err
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned NSLOT  = NR + 1;
  localparam int unsigned WORD_W = 32;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  // Rcon used when deriving slot[cnt] from slot[cnt+1]
  function automatic logic [7:0] rcon(input logic [CNT_W-1:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd0:    rc = 8'h01;
      4'd1:    rc = 8'h02;
      4'd2:    rc = 8'h04;
      4'd3:    rc = 8'h08;
      4'd4:    rc = 8'h10;
      4'd5:    rc = 8'h20;
      4'd6:    rc = 8'h40;
      4'd7:    rc = 8'h80;
      4'd8:    rc = 8'h1b;
      default: rc = 8'h36;
    endcase
    return rc;
  endfunction

  function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // One inverse key-schedule step: recover round key i from round key i+1
  function automatic logic [KEY_W-1:0] inv_round(input logic [KEY_W-1:0] nk,
                                                 input logic [7:0]       rc);
    logic [WORD_W-1:0] n0, n1, n2, n3, c0, c1, c2, c3;
    n0 = nk[127:96];
    n1 = nk[95:64];
    n2 = nk[63:32];
    n3 = nk[31:0];
    c3 = n2 ^ n3;
    c2 = n1 ^ n2;
    c1 = n0 ^ n1;
    c0 = n0 ^ sub_word({c3[23:0], c3[31:24]}) ^ {rc, 24'h000000};
    return {c0, c1, c2, c3};
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             rd_ack_q, rd_ack_d;
  logic             rd_err_q, rd_err_d;
  logic [KEY_W-1:0] rd_key_q, rd_key_d;
  logic [KEY_W-1:0] slot_q [NSLOT];

  logic             load_en;
  logic             exp_en;
  logic             rd_avail;
  logic [KEY_W-1:0] exp_key;

  assign exp_key = inv_round(slot_q[cnt_q + 4'd1], rcon(cnt_q));

  // Next-state, expansion control and read response
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    ready_d  = ready_q;
    rd_ack_d = 1'b0;
    rd_err_d = 1'b0;
    rd_key_d = rd_key_q;
    load_en  = 1'b0;
    exp_en   = 1'b0;
    rd_avail = 1'b0;

    case (state_q)
      IDLE: begin
        if (key_load) begin
          load_en = 1'b1;
          cnt_d   = CNT_W'(NR - 1);
          busy_d  = 1'b1;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        exp_en   = 1'b1;
        rd_avail = (rd_round > cnt_q);
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          busy_d  = 1'b0;
          ready_d = 1'b1;
          state_d = READY;
        end
      end
      READY: begin
        rd_avail = 1'b1;
        if (key_load) begin
          load_en = 1'b1;
          cnt_d   = CNT_W'(NR - 1);
          busy_d  = 1'b1;
          ready_d = 1'b0;
          state_d = EXPAND;
        end
      end
      default: state_d = IDLE;
    endcase

    // A request still high during its own ack cycle is not accepted again that cycle
    if (rd_req && !rd_ack_q) begin
      if (rd_round > CNT_W'(NR)) begin
        rd_ack_d = 1'b1;
        rd_err_d = 1'b1;
        rd_key_d = '0;
      end else if (rd_avail) begin
        rd_ack_d = 1'b1;
        rd_key_d = slot_q[rd_round];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      rd_ack_q <= 1'b0;
      rd_err_q <= 1'b0;
      rd_key_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      rd_ack_q <= rd_ack_d;
      rd_err_q <= rd_err_d;
      rd_key_q <= rd_key_d;
    end
  end

  // Key storage is never read before a load, so it carries no reset
  always_ff @(posedge clk) begin
    if (load_en) begin
      slot_q[NR] <= key_in;
    end
    if (exp_en) begin
      slot_q[cnt_q] <= exp_key;
    end
  end

  assign busy       = busy_q;
  assign keys_ready = ready_q;
  assign rd_ack     = rd_ack_q;
  assign rd_err     = rd_err_q;
  assign rd_key     = rd_key_q;

endmodule

// File: tb/tb_inv_key_sched_ctrl.sv
// Directed bench for inv_key_sched_ctrl using FIPS-197 and all-zero-key AES-128 round keys.
module tb_inv_key_sched_ctrl;

  localparam logic [127:0] KA10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KA9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] KA1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KA0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KB10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] KB1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] KB0  = 128'h0;

  logic         clk;
  logic         rst_n;
  logic         key_load;
  logic [127:0] key_in;
  logic         busy;
  logic         keys_ready;
  logic         rd_req;
  logic [3:0]   rd_round;
  logic         rd_ack;
  logic [127:0] rd_key;
  logic         rd_err;

  int n_tests = 0;
  int n_fail  = 0;

  inv_key_sched_ctrl #(.KEY_W(128), .NR(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_load   (key_load),
    .key_in     (key_in),
    .busy       (busy),
    .keys_ready (keys_ready),
    .rd_req     (rd_req),
    .rd_round   (rd_round),
    .rd_ack     (rd_ack),
    .rd_key     (rd_key),
    .rd_err     (rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input string tag, input logic [3:0] r,
                         input logic [127:0] ek, input logic ee);
    int n;
    rd_round = r;
    rd_req   = 1'b1;
    n        = 0;
    do begin
      tick();
      n++;
    end while (!rd_ack && n < 30);
    rd_req = 1'b0;
    check({tag, "_ack"}, 128'(rd_ack), 128'(1));
    check({tag, "_key"}, rd_key, ek);
    check({tag, "_err"}, 128'(rd_err), 128'(ee));
    tick();
  endtask

  task automatic load_key(input logic [127:0] k);
    key_in   = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!keys_ready && n < 30) begin
      tick();
      n++;
    end
    check(tag, 128'(keys_ready), 128'(1));
  endtask

  initial begin
    int acks;
    rst_n    = 1'b0;
    key_load = 1'b0;
    key_in   = '0;
    rd_req   = 1'b0;
    rd_round = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  128'(busy),       128'(0));
    check("rst_ready", 128'(keys_ready), 128'(0));
    check("rst_ack",   128'(rd_ack),     128'(0));
    check("rst_err",   128'(rd_err),     128'(0));
    check("rst_key",   rd_key,           128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Out-of-range read in IDLE, valid round in IDLE never acked
    do_read("idle_r11", 4'd11, 128'(0), 1'b1);
    rd_req   = 1'b1;
    rd_round = 4'd0;
    acks     = 0;
    repeat (4) begin
      tick();
      if (rd_ack) acks++;
    end
    rd_req = 1'b0;
    check("idle_r0_noack", 128'(acks), 128'(0));
    tick();

    // Expansion latency and first key
    load_key(KA10);
    check("t1_ready_low", 128'(keys_ready), 128'(0));
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t1_busy_c%0d", i + 1), 128'(busy), 128'(1));
      tick();
    end
    check("t1_busy_done", 128'(busy),       128'(0));
    check("t1_ready_t11", 128'(keys_ready), 128'(1));
    do_read("t1_r0", 4'd0, KA0, 1'b0);

    do_read("t2_r9", 4'd9, KA9, 1'b0);
    do_read("t2_r1", 4'd1, KA1, 1'b0);

    do_read("rdy_r15", 4'd15, 128'(0), 1'b1);
    do_read("rdy_r11", 4'd11, 128'(0), 1'b1);

    // Reads during expansion: slot 10 immediately, slot 0 only once READY
    load_key(KA10);
    check("t3_ready_drop", 128'(keys_ready), 128'(0));
    rd_round = 4'd10;
    rd_req   = 1'b1;
    tick();
    check("t3_r10_ack", 128'(rd_ack), 128'(1));
    check("t3_r10_key", rd_key, KA10);
    rd_round = 4'd0;
    acks     = 0;
    for (int c = 3; c <= 11; c++) begin
      tick();
      if (rd_ack) acks++;
    end
    check("t3_r0_withheld", 128'(acks), 128'(0));
    tick();
    rd_req = 1'b0;
    check("t3_r0_ack", 128'(rd_ack), 128'(1));
    check("t3_r0_key", rd_key, KA0);
    tick();

    // key_load during EXPAND is ignored
    load_key(KA10);
    repeat (3) tick();
    load_key(KB10);
    wait_ready("t5_ready");
    do_read("t5_r0", 4'd0, KA0, 1'b0);
    do_read("t5_r10", 4'd10, KA10, 1'b0);

    // Load and read in the same READY cycle: old key returned
    key_in   = KB10;
    key_load = 1'b1;
    rd_round = 4'd0;
    rd_req   = 1'b1;
    tick();
    key_load = 1'b0;
    rd_req   = 1'b0;
    check("t5_sim_ack",   128'(rd_ack),     128'(1));
    check("t5_sim_key",   rd_key,           KA0);
    check("t5_sim_ready", 128'(keys_ready), 128'(0));
    check("t5_sim_busy",  128'(busy),       128'(1));
    repeat (9) tick();
    check("t5_b_ready_t10", 128'(keys_ready), 128'(0));
    tick();
    check("t5_b_ready_t11", 128'(keys_ready), 128'(1));
    do_read("t5_b_r0", 4'd0, KB0, 1'b0);
    do_read("t5_b_r1", 4'd1, KB1, 1'b0);
    do_read("t5_b_r10", 4'd10, KB10, 1'b0);

    // Asynchronous reset mid-expansion with a pending read
    load_key(KA10);
    repeat (5) tick();
    rd_round = 4'd0;
    rd_req   = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_busy",  128'(busy),       128'(0));
    check("t6_ready", 128'(keys_ready), 128'(0));
    check("t6_ack",   128'(rd_ack),     128'(0));
    check("t6_key",   rd_key,           128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    acks  = 0;
    repeat (12) begin
      tick();
      if (rd_ack) acks++;
    end
    check("t6_pending_noack", 128'(acks), 128'(0));
    load_key(KA10);
    acks = 0;
    while (!rd_ack && acks < 30) begin
      tick();
      acks++;
    end
    rd_req = 1'b0;
    check("t6_reload_ack", 128'(rd_ack), 128'(1));
    check("t6_reload_key", rd_key, KA0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
